pe_array_ctrl: RTL and testbench

//  Sequencer for the 2x16 PE array: runs one accumulation tile. Reads K input rows and K weight pairs from
//  the operand buffers, drives the PE add_number/keep/rounder_en controls with matching timing, triggers

---
 rtl/pe_ctrl_pkg.sv | 31 +++
 rtl/pe_ctrl_delay_pipe.sv | 43 ++++
 rtl/pe_array_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_ctrl_pkg
//  Purpose  : Shared types and constants for the 2x16 PE array sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

  localparam int PE_ROWS  = 2;
  localparam int PE_COLS  = 16;
  localparam int ACC_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = $clog2(ACC_REGS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ALIGN = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_e;

  // One MAC step's PE controls, travelling alongside the operand read latency.
  typedef struct packed {
    logic             mac_valid;
    logic             keep;
    logic [ACC_W-1:0] add_number;
  } pe_step_t;

endpackage
`default_nettype wire

// File: rtl/pe_ctrl_delay_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : pe_ctrl_delay_pipe
//  Purpose  : DEPTH-stage register chain delaying PE step controls so they
//             line up with operand data returning from the buffers.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_ctrl_delay_pipe
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  pe_step_t step_i,
  output pe_step_t step_o
);

  pe_step_t stage_q [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      // First stage captures the step issued this cycle; flush drops it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          stage_q[g] <= '0;
        else if (flush_i) stage_q[g] <= '0;
        else              stage_q[g] <= step_i;
      end
    end else begin : g_tail
      // Later stages shift the step forward; flush empties the whole chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          stage_q[g] <= '0;
        else if (flush_i) stage_q[g] <= '0;
        else              stage_q[g] <= stage_q[g-1];
      end
    end
  end

  assign step_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pe_array_ctrl
//  Purpose  : Runs one accumulation tile on the 2x16 PE array: issues K
//             operand reads, drives aligned PE controls, triggers rounding
//             and hands the result to writeback over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int K_MAX  = 256,
  parameter int RD_LAT = 1,
  parameter int RND_TO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cfg_k_len,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [3:0]        cfg_acc_sel,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  output logic [3:0]        pe_add_number,
  output logic              pe_keep,
  output logic              pe_rounder_en,
  input  logic              pe_rounder_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              CNT_W  = ADDR_W + 1;
  localparam int              TMO_W  = $clog2(RND_TO + 1);
  localparam logic [CNT_W:0]  K_LIMIT = (CNT_W + 1)'(K_MAX);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    k_len_q, k_len_d;
  logic [ADDR_W-1:0]   in_base_q, in_base_d;
  logic [ADDR_W-1:0]   wt_base_q, wt_base_d;
  logic [ACC_W-1:0]    acc_q, acc_d;

  logic                w_k_bad;
  logic                w_issue;
  pe_step_t            w_step_in;
  pe_step_t            w_step_out;

  // Depth 0 and anything above K_MAX cannot be sequenced.
  assign w_k_bad = (cfg_k_len == '0) || ({1'b0, cfg_k_len} > K_LIMIT);

  // State, counters, latched configuration and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      k_len_q   <= '0;
      in_base_q <= '0;
      wt_base_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      k_len_q   <= k_len_d;
      in_base_q <= in_base_d;
      wt_base_q <= wt_base_d;
      acc_q     <= acc_d;
    end
  end

  // Next-state logic and state-decoded strobes; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    tmo_d         = tmo_q;
    err_d         = err_q;
    k_len_d       = k_len_q;
    in_base_d     = in_base_q;
    wt_base_d     = wt_base_q;
    acc_d         = acc_q;
    w_issue       = 1'b0;
    pe_rounder_en = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_k_bad) begin
            err_d = 1'b1;
          end else begin
            k_len_d   = cfg_k_len;
            in_base_d = cfg_in_base;
            wt_base_d = cfg_wt_base;
            acc_d     = cfg_acc_sel;
            err_d     = 1'b0;
            step_d    = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (step_q == k_len_q - CNT_W'(1)) begin
          step_d  = '0;
          state_d = ALIGN;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      ALIGN: begin
        if (step_q == CNT_W'(RD_LAT - 1)) begin
          tmo_d   = '0;
          state_d = ROUND;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      ROUND: begin
        pe_rounder_en = (tmo_q == '0);
        if (pe_rounder_valid) begin
          state_d = OUT;
        end else if (tmo_q == TMO_W'(RND_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
      tmo_d   = '0;
      err_d   = err_q;
      done    = 1'b0;
    end
  end

  assign in_rd_en   = w_issue;
  assign wt_rd_en   = w_issue;
  assign in_rd_addr = w_issue ? (in_base_q + step_q[ADDR_W-1:0]) : '0;
  assign wt_rd_addr = w_issue ? (wt_base_q + step_q[ADDR_W-1:0]) : '0;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

  // Step 0 overwrites the accumulator, later steps accumulate.
  assign w_step_in.mac_valid  = w_issue;
  assign w_step_in.keep       = (step_q != '0);
  assign w_step_in.add_number = acc_q;

  pe_ctrl_delay_pipe #(
    .DEPTH (RD_LAT)
  ) u_delay_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .step_i  (w_step_in),
    .step_o  (w_step_out)
  );

  assign pe_add_number = w_step_out.mac_valid ? w_step_out.add_number : '0;
  assign pe_keep       = w_step_out.mac_valid & w_step_out.keep;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_array_ctrl
//  Purpose  : Directed self-checking bench for pe_array_ctrl (RD_LAT = 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_array_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [8:0] cfg_k_len;
  logic [7:0] cfg_in_base;
  logic [7:0] cfg_wt_base;
  logic [3:0] cfg_acc_sel;
  logic       in_rd_en;
  logic [7:0] in_rd_addr;
  logic       wt_rd_en;
  logic [7:0] wt_rd_addr;
  logic [3:0] pe_add_number;
  logic       pe_keep;
  logic       pe_rounder_en;
  logic       pe_rounder_valid;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         k;
    logic [7:0] ib;
    logic [7:0] wb;
    logic [3:0] acc;
    int         rnd_wait;
    int         rdy_wait;
    logic [7:0] exp_last_in;
    logic [7:0] exp_last_wt;
  } vec_t;

  vec_t vecs [5];

  pe_array_ctrl #(
    .ADDR_W (8),
    .K_MAX  (256),
    .RD_LAT (1),
    .RND_TO (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_k_len        (cfg_k_len),
    .cfg_in_base      (cfg_in_base),
    .cfg_wt_base      (cfg_wt_base),
    .cfg_acc_sel      (cfg_acc_sel),
    .in_rd_en         (in_rd_en),
    .in_rd_addr       (in_rd_addr),
    .wt_rd_en         (wt_rd_en),
    .wt_rd_addr       (wt_rd_addr),
    .pe_add_number    (pe_add_number),
    .pe_keep          (pe_keep),
    .pe_rounder_en    (pe_rounder_en),
    .pe_rounder_valid (pe_rounder_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Entered mid-low-phase of an IDLE cycle; leaves mid-low-phase of the IDLE
  // cycle after done, so a following call starts back-to-back.
  task automatic run_tile(input vec_t v);
    logic [7:0] ea;
    logic [7:0] eb;
    chk("idle_busy", busy, 0);
    start       = 1'b1;
    cfg_k_len   = 9'(v.k);
    cfg_in_base = v.ib;
    cfg_wt_base = v.wb;
    cfg_acc_sel = v.acc;
    next_cycle();
    start     = 1'b0;
    cfg_k_len = 9'd0;
    #1;
    chk("err_cleared", err, 0);
    for (int i = 0; i < v.k; i++) begin
      ea = 8'(v.ib + 8'(i));
      eb = 8'(v.wb + 8'(i));
      chk("issue_in_en", in_rd_en, 1);
      chk("issue_wt_en", wt_rd_en, 1);
      chk("issue_in_addr", in_rd_addr, ea);
      chk("issue_wt_addr", wt_rd_addr, eb);
      chk("issue_busy", busy, 1);
      chk("issue_add", pe_add_number, (i == 0) ? 4'd0 : v.acc);
      chk("issue_keep", pe_keep, (i >= 2) ? 1 : 0);
      if (i == v.k - 1) begin
        chk("last_in_addr", in_rd_addr, v.exp_last_in);
        chk("last_wt_addr", wt_rd_addr, v.exp_last_wt);
      end
      next_cycle();
      #1;
    end
    // ALIGN: last step reaches the PE, no new reads.
    chk("align_in_en", in_rd_en, 0);
    chk("align_add", pe_add_number, v.acc);
    chk("align_keep", pe_keep, (v.k > 1) ? 1 : 0);
    chk("align_rnd_en", pe_rounder_en, 0);
    next_cycle();
    for (int r = 0; r <= v.rnd_wait; r++) begin
      pe_rounder_valid = (r == v.rnd_wait);
      #1;
      chk("round_en", pe_rounder_en, (r == 0) ? 1 : 0);
      chk("round_add", pe_add_number, 0);
      chk("round_keep", pe_keep, 0);
      chk("round_out_valid", out_valid, 0);
      next_cycle();
    end
    pe_rounder_valid = 1'b0;
    for (int c = 0; c <= v.rdy_wait; c++) begin
      out_ready = (c == v.rdy_wait);
      start     = (c < v.rdy_wait);
      cfg_k_len = 9'd2;
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_done", done, (c == v.rdy_wait) ? 1 : 0);
      chk("out_rnd_en", pe_rounder_en, 0);
      chk("out_in_en", in_rd_en, 0);
      next_cycle();
    end
    out_ready = 1'b0;
    start     = 1'b0;
    cfg_k_len = 9'd0;
    #1;
    chk("post_out_valid", out_valid, 0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_err", err, 0);
    if (v.rdy_wait > 0) begin
      // A start seen during OUT must not have been queued.
      next_cycle();
      #1;
      chk("no_queued_start", busy, 0);
      chk("no_queued_rd", in_rd_en, 0);
    end
  endtask

  initial begin
    vecs[0] = '{k: 4,   ib: 8'h10, wb: 8'h20, acc: 4'd3,  rnd_wait: 0, rdy_wait: 0,
                exp_last_in: 8'h13, exp_last_wt: 8'h23};
    vecs[1] = '{k: 3,   ib: 8'hFE, wb: 8'h40, acc: 4'd5,  rnd_wait: 2, rdy_wait: 0,
                exp_last_in: 8'h00, exp_last_wt: 8'h42};
    vecs[2] = '{k: 1,   ib: 8'h00, wb: 8'hFF, acc: 4'd15, rnd_wait: 0, rdy_wait: 5,
                exp_last_in: 8'h00, exp_last_wt: 8'hFF};
    vecs[3] = '{k: 2,   ib: 8'h80, wb: 8'h7F, acc: 4'd0,  rnd_wait: 1, rdy_wait: 1,
                exp_last_in: 8'h81, exp_last_wt: 8'h80};
    vecs[4] = '{k: 256, ib: 8'h05, wb: 8'h00, acc: 4'd9,  rnd_wait: 0, rdy_wait: 0,
                exp_last_in: 8'h04, exp_last_wt: 8'hFF};

    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    cfg_k_len        = 9'd0;
    cfg_in_base      = 8'd0;
    cfg_wt_base      = 8'd0;
    cfg_acc_sel      = 4'd0;
    pe_rounder_valid = 1'b0;
    out_ready        = 1'b0;

    next_cycle();
    next_cycle();
    chk("rst_busy", busy, 0);
    chk("rst_in_en", in_rd_en, 0);
    chk("rst_wt_en", wt_rd_en, 0);
    chk("rst_add", pe_add_number, 0);
    chk("rst_keep", pe_keep, 0);
    chk("rst_rnd_en", pe_rounder_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    next_cycle();
    #1;

    // Table: all tiles back-to-back.
    for (int v = 0; v < 5; v++) run_tile(vecs[v]);

    // Zero-depth start: error, no activity; next good start clears it.
    start     = 1'b1;
    cfg_k_len = 9'd0;
    next_cycle();
    start = 1'b0;
    #1;
    chk("k0_err", err, 1);
    chk("k0_busy", busy, 0);
    chk("k0_in_en", in_rd_en, 0);
    next_cycle();
    #1;
    chk("k0_busy_hold", busy, 0);
    chk("k0_wt_en", wt_rd_en, 0);
    chk("k0_err_sticky", err, 1);
    run_tile(vecs[2]);

    // Rounding timeout: no rounder_valid ever.
    start       = 1'b1;
    cfg_k_len   = 9'd2;
    cfg_in_base = 8'h00;
    cfg_wt_base = 8'h00;
    cfg_acc_sel = 4'd1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    for (int r = 0; r < 64; r++) begin
      #1;
      chk("tmo_busy", busy, 1);
      chk("tmo_rnd_en", pe_rounder_en, (r == 0) ? 1 : 0);
      chk("tmo_out_valid", out_valid, 0);
      next_cycle();
    end
    #1;
    chk("tmo_idle", busy, 0);
    chk("tmo_err", err, 1);
    chk("tmo_out_valid_after", out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      chk("tmo_out_valid_never", out_valid, 0);
    end
    run_tile(vecs[1]);

    // Abort in the third ISSUE cycle of a K=8 tile.
    start       = 1'b1;
    cfg_k_len   = 9'd8;
    cfg_in_base = 8'h30;
    cfg_wt_base = 8'h60;
    cfg_acc_sel = 4'd6;
    next_cycle();
    start     = 1'b0;
    cfg_k_len = 9'd0;
    #1;
    chk("abt_addr0", in_rd_addr, 8'h30);
    next_cycle();
    next_cycle();
    abort = 1'b1;
    #1;
    chk("abt_addr2", in_rd_addr, 8'h32);
    chk("abt_done_same", done, 0);
    next_cycle();
    abort = 1'b0;
    #1;
    chk("abt_busy", busy, 0);
    chk("abt_in_en", in_rd_en, 0);
    chk("abt_wt_en", wt_rd_en, 0);
    chk("abt_add", pe_add_number, 0);
    chk("abt_keep", pe_keep, 0);
    chk("abt_rnd_en", pe_rounder_en, 0);
    chk("abt_out_valid", out_valid, 0);
    chk("abt_done", done, 0);
    next_cycle();
    #1;
    chk("abt_busy_hold", busy, 0);
    chk("abt_add_hold", pe_add_number, 0);
    run_tile(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
